// File: rtl/tick_serial_tx.sv
// Tick-paced frame serializer: accepts a parallel word over valid/ready and shifts it
// out LSB-first as start, data, optional even-parity and stop bits, one bit per tick.
module tick_serial_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY_EN = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t              state, state_d;
  logic [DATA_W-1:0]   shift, shift_d;
  logic                par, par_d;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_d;
  logic [1:0]          stop_cnt, stop_cnt_d;
  logic                tx_d, busy_d, done_d;

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= '0;
      par      <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      shift    <= shift_d;
      par      <= par_d;
      bit_cnt  <= bit_cnt_d;
      stop_cnt <= stop_cnt_d;
      tx       <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next state; tx_d is the value of the bit that starts on this tick
  always_comb begin
    state_d    = state;
    shift_d    = shift;
    par_d      = par;
    bit_cnt_d  = bit_cnt;
    stop_cnt_d = stop_cnt;
    tx_d       = tx;
    busy_d     = busy;
    done_d     = 1'b0;

    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (in_valid) begin
          shift_d    = in_data;
          par_d      = ^in_data;
          bit_cnt_d  = '0;
          stop_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = ALIGN;
        end
      end
      ALIGN: begin
        if (tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          tx_d    = shift[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = shift >> 1;
          bit_cnt_d = bit_cnt + CNT_W'(1);
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            if (PARITY_EN != 0) begin
              tx_d    = par;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (stop_cnt == 2'(STOP_BITS - 1)) begin
            stop_cnt_d = '0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end else begin
            stop_cnt_d = stop_cnt + 2'd1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready = (state == IDLE);

endmodule

// File: tb/tb_tick_serial_tx.sv
// Directed bench for tick_serial_tx: 8N1, 8E1 and 8N2 instances driven by scenario tasks.
module tb_tick_serial_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       va = 1'b0, vp = 1'b0, vs = 1'b0;
  logic       rdy_a, tx_a, busy_a, done_a;
  logic       rdy_p, tx_p, busy_p, done_p;
  logic       rdy_s, tx_s, busy_s, done_s;
  logic [1:0] sel = 2'd0;
  logic       tx_m, busy_m, done_m, rdy_m;

  int vectors = 0;
  int miscompares = 0;

  logic tx_q   [0:127];
  logic done_q [0:127];
  logic busy_q [0:127];
  logic rdy_q  [0:127];

  always #5 clk = ~clk;

  tick_serial_tx dut_a (.clk(clk), .reset(reset), .tick(tick), .in_valid(va), .in_data(in_data),
                        .in_ready(rdy_a), .tx(tx_a), .busy(busy_a), .done(done_a));
  tick_serial_tx #(.PARITY_EN(1)) dut_p (.clk(clk), .reset(reset), .tick(tick), .in_valid(vp),
                        .in_data(in_data), .in_ready(rdy_p), .tx(tx_p), .busy(busy_p), .done(done_p));
  tick_serial_tx #(.STOP_BITS(2)) dut_s (.clk(clk), .reset(reset), .tick(tick), .in_valid(vs),
                        .in_data(in_data), .in_ready(rdy_s), .tx(tx_s), .busy(busy_s), .done(done_s));

  always_comb begin
    tx_m = tx_a; busy_m = busy_a; done_m = done_a; rdy_m = rdy_a;
    if (sel == 2'd1) begin
      tx_m = tx_p; busy_m = busy_p; done_m = done_p; rdy_m = rdy_p;
    end else if (sel == 2'd2) begin
      tx_m = tx_s; busy_m = busy_s; done_m = done_s; rdy_m = rdy_s;
    end
  end

  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic set_valid(input logic v);
    va = (sel == 2'd0) ? v : 1'b0;
    vp = (sel == 2'd1) ? v : 1'b0;
    vs = (sel == 2'd2) ? v : 1'b0;
  endtask

  task automatic do_reset();
    va = 1'b0; vp = 1'b0; vs = 1'b0; tick = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic accept(input logic [7:0] d, input logic t);
    in_data = d;
    set_valid(1'b1);
    cyc(t);
    set_valid(1'b0);
  endtask

  // Records outputs for n cycles with a tick on every p-th cycle (first at k=p-1)
  task automatic capture(input int n, input int p, input bit scramble);
    for (int k = 0; k < n; k++) begin
      if (scramble) in_data = 8'($urandom);
      cyc(logic'((k % p) == p - 1));
      tx_q[k] = tx_m; done_q[k] = done_m; busy_q[k] = busy_m; rdy_q[k] = rdy_m;
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #0;
      vectors++;
      if ({tx_m, busy_m, done_m, rdy_m} !== 4'b1001) begin
        miscompares++;
        $display("FAIL reset dut%0d {tx,busy,done,rdy}=%b exp=1001", s, {tx_m, busy_m, done_m, rdy_m});
      end
    end
    sel = 2'd0;
  endtask

  task automatic test_basic_8n1();
    logic [9:0] frame = 10'b1101001010;
    logic       e;
    int         b;
    do_reset(); sel = 2'd0;
    accept(8'hA5, 1'b0);
    vectors++;
    if ({busy_m, rdy_m, tx_m} !== 3'b101) begin
      miscompares++;
      $display("FAIL basic_accept {busy,rdy,tx}=%b exp=101", {busy_m, rdy_m, tx_m});
    end
    capture(40, 3, 1'b0);
    for (int k = 0; k < 40; k++) begin
      b = (k - 2) / 3;
      e = (k < 2 || b >= 10) ? 1'b1 : frame[b];
      vectors++;
      if (tx_q[k] !== e || done_q[k] !== logic'(k == 32) || busy_q[k] !== logic'(k < 32)) begin
        miscompares++;
        $display("FAIL basic k=%0d tx=%b/%b done=%b/%b busy=%b/%b", k, tx_q[k], e,
                 done_q[k], logic'(k == 32), busy_q[k], logic'(k < 32));
      end
    end
  endtask

  task automatic test_parity();
    logic [10:0] frames [2] = '{11'b11000001110, 11'b10000000110};
    logic [7:0]  words  [2] = '{8'h07, 8'h03};
    logic        e;
    int          b;
    do_reset(); sel = 2'd1;
    for (int f = 0; f < 2; f++) begin
      accept(words[f], 1'b0);
      capture(26, 2, 1'b0);
      for (int k = 0; k < 26; k++) begin
        b = (k - 1) / 2;
        e = (k < 1 || b >= 11) ? 1'b1 : frames[f][b];
        vectors++;
        if (tx_q[k] !== e || done_q[k] !== logic'(k == 23)) begin
          miscompares++;
          $display("FAIL parity w=%h k=%0d tx=%b/%b done=%b/%b", words[f], k, tx_q[k], e,
                   done_q[k], logic'(k == 23));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] f1 = 11'b11100000010;
    logic [10:0] f2 = 11'b11010000100;
    logic        e, ed, er;
    int          b;
    do_reset(); sel = 2'd2;
    in_data = 8'h81;
    set_valid(1'b1);
    cyc(1'b0);
    in_data = 8'h42;
    capture(74, 3, 1'b0);
    set_valid(1'b0);
    for (int k = 0; k < 74; k++) begin
      if (k < 38) begin
        b = (k - 2) / 3;
        e = (k < 2 || b >= 11) ? 1'b1 : f1[b];
      end else begin
        b = (k - 38) / 3;
        e = (b >= 11) ? 1'b1 : f2[b];
      end
      ed = logic'(k == 35 || k == 71);
      er = ed;
      vectors++;
      if (tx_q[k] !== e || done_q[k] !== ed || rdy_q[k] !== er) begin
        miscompares++;
        $display("FAIL b2b k=%0d tx=%b/%b done=%b/%b rdy=%b/%b", k, tx_q[k], e,
                 done_q[k], ed, rdy_q[k], er);
      end
    end
  endtask

  task automatic test_tick_in_accept();
    logic [9:0] frame = 10'b1001111000;
    logic       e;
    int         b;
    do_reset(); sel = 2'd0;
    accept(8'h3C, 1'b1);
    vectors++;
    if ({busy_m, tx_m} !== 2'b11) begin
      miscompares++;
      $display("FAIL tick_accept {busy,tx}=%b exp=11", {busy_m, tx_m});
    end
    capture(36, 3, 1'b1);
    for (int k = 0; k < 36; k++) begin
      b = (k - 2) / 3;
      e = (k < 2 || b >= 10) ? 1'b1 : frame[b];
      vectors++;
      if (tx_q[k] !== e || done_q[k] !== logic'(k == 32)) begin
        miscompares++;
        $display("FAIL tick_accept k=%0d tx=%b/%b done=%b/%b", k, tx_q[k], e,
                 done_q[k], logic'(k == 32));
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [9:0] frame = 10'b1101001010;
    logic       e;
    int         b;
    do_reset(); sel = 2'd0;
    accept(8'h00, 1'b0);
    capture(18, 3, 1'b0);
    vectors++;
    if ({tx_m, busy_m} !== 2'b01) begin
      miscompares++;
      $display("FAIL mid_before {tx,busy}=%b exp=01", {tx_m, busy_m});
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({tx_m, busy_m, done_m, rdy_m} !== 4'b1001) begin
      miscompares++;
      $display("FAIL mid_async {tx,busy,done,rdy}=%b exp=1001", {tx_m, busy_m, done_m, rdy_m});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    capture(40, 3, 1'b0);
    for (int k = 0; k < 40; k++) begin
      vectors++;
      if (done_q[k] !== 1'b0 || tx_q[k] !== 1'b1 || busy_q[k] !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_quiet k=%0d done=%b tx=%b busy=%b exp=0,1,0", k, done_q[k], tx_q[k], busy_q[k]);
      end
    end
    accept(8'hA5, 1'b0);
    capture(34, 3, 1'b0);
    for (int k = 0; k < 34; k++) begin
      b = (k - 2) / 3;
      e = (k < 2 || b >= 10) ? 1'b1 : frame[b];
      vectors++;
      if (tx_q[k] !== e || done_q[k] !== logic'(k == 32)) begin
        miscompares++;
        $display("FAIL mid_next k=%0d tx=%b/%b done=%b/%b", k, tx_q[k], e, done_q[k], logic'(k == 32));
      end
    end
  endtask

  task automatic test_stuck_tick();
    logic [9:0] frame = 10'b1010110100;
    logic       e;
    do_reset(); sel = 2'd0;
    accept(8'h5A, 1'b1);
    capture(13, 1, 1'b0);
    for (int k = 0; k < 13; k++) begin
      e = (k >= 10) ? 1'b1 : frame[k];
      vectors++;
      if (tx_q[k] !== e || done_q[k] !== logic'(k == 10)) begin
        miscompares++;
        $display("FAIL stuck k=%0d tx=%b/%b done=%b/%b", k, tx_q[k], e, done_q[k], logic'(k == 10));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_parity();
    test_back_to_back();
    test_tick_in_accept();
    test_reset_midframe();
    test_stuck_tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
